// File: rtl/ms_ff_bank_if.sv
// Bus bundle for ms_ff_bank: mode/operand inputs, ILL clear, state and flag outputs.
// MS_FF_ILLCNT_EN adds the ILL_CNT illegal-event counter signal.
interface ms_ff_bank_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
);
    logic             EN;
    logic [1:0]       MODE;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ILL_CLR;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qbar;
    logic             ILL;
`ifdef MS_FF_ILLCNT_EN
    logic [CNT_W-1:0] ILL_CNT;
`endif

    // Reject out-of-range sizes at elaboration time
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("ms_ff_bank_if: WIDTH must be 1..32");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("ms_ff_bank_if: CNT_W must be 1..32");
    end

    // Stimulus side: drives controls and operands, observes state
    modport master (
        output EN, MODE, A, B, ILL_CLR,
        input  Q, Qbar, ILL
`ifdef MS_FF_ILLCNT_EN
        , input ILL_CNT
`endif
    );

    // Flip-flop bank side
    modport slave (
        input  EN, MODE, A, B, ILL_CLR,
        output Q, Qbar, ILL
`ifdef MS_FF_ILLCNT_EN
        , output ILL_CNT
`endif
    );
endinterface

// File: rtl/ms_ff_bank.sv
// ms_ff_bank: WIDTH-bit bank of edge-triggered flip-flops whose behaviour is
// selected per cycle by MODE (SR, JK, D, T), with a sticky flag for SR S=R=1.
// Optional macro MS_FF_ILLCNT_EN adds a saturating illegal-event counter.
module ms_ff_bank #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic C,
    input  logic CLR,
    ms_ff_bank_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("ms_ff_bank: WIDTH must be 1..32");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("ms_ff_bank: CNT_W must be 1..32");
    end

    mode_e            w_mode;
    logic [WIDTH-1:0] w_q_next;
    logic             w_ill_evt;
    logic [WIDTH-1:0] r_q;
    logic             r_ill;

    assign w_mode = mode_e'(bus.MODE);

    // Illegal event: SR mode, enabled, any bit with S=R=1 (one event per edge)
    assign w_ill_evt = bus.EN && (w_mode == MODE_SR) && (|(bus.A & bus.B));

    // Per-bit next state from the sampled mode and operands
    always_comb begin
        w_q_next = r_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            case (w_mode)
                MODE_SR: begin
                    case ({bus.A[i], bus.B[i]})
                        2'b10:   w_q_next[i] = 1'b1;
                        2'b01:   w_q_next[i] = 1'b0;
                        default: w_q_next[i] = r_q[i];
                    endcase
                end
                MODE_JK: begin
                    case ({bus.A[i], bus.B[i]})
                        2'b10:   w_q_next[i] = 1'b1;
                        2'b01:   w_q_next[i] = 1'b0;
                        2'b11:   w_q_next[i] = ~r_q[i];
                        default: w_q_next[i] = r_q[i];
                    endcase
                end
                MODE_D: begin
                    w_q_next[i] = bus.A[i];
                end
                default: begin
                    w_q_next[i] = bus.A[i] ? ~r_q[i] : r_q[i];
                end
            endcase
        end
    end

    // State register: synchronous clear, then clock enable
    always_ff @(posedge C) begin
        if (CLR) begin
            r_q <= '0;
        end else if (bus.EN) begin
            r_q <= w_q_next;
        end
    end

    // Sticky illegal flag: a new event wins over a simultaneous clear request
    always_ff @(posedge C) begin
        if (CLR) begin
            r_ill <= 1'b0;
        end else if (w_ill_evt) begin
            r_ill <= 1'b1;
        end else if (bus.ILL_CLR) begin
            r_ill <= 1'b0;
        end
    end

`ifdef MS_FF_ILLCNT_EN
    logic [CNT_W-1:0] r_ill_cnt;

    // Saturating event counter, cleared only by CLR
    always_ff @(posedge C) begin
        if (CLR) begin
            r_ill_cnt <= '0;
        end else if (w_ill_evt && (r_ill_cnt != '1)) begin
            r_ill_cnt <= r_ill_cnt + 1'b1;
        end
    end

    assign bus.ILL_CNT = r_ill_cnt;
`endif

    assign bus.Q    = r_q;
    assign bus.Qbar = ~r_q;
    assign bus.ILL  = r_ill;
endmodule

// File: doc/ms_ff_bank.md
MS_FF_BANK -- requirements
Module: ms_ff_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of flip-flop bits in the bank, legal range 1..32.
REQ-002 Parameter CNT_W, default 8: width of the illegal-event counter, used only when MS_FF_ILLCNT_EN is defined.
REQ-003 C  input  1  clock; all state updates on the rising edge; one clock domain only.
REQ-004 CLR  input  1  reset, synchronous, active-high.
REQ-005 EN  input  1  clock enable; when 0, Q holds for every bit.
REQ-006 MODE  input  2  bank mode: 00=SR, 01=JK, 10=D, 11=T.
REQ-007 A  input  WIDTH  per-bit first operand: S in SR, J in JK, D in D, T in T.
REQ-008 B  input  WIDTH  per-bit second operand: R in SR, K in JK; ignored in D and T.
REQ-009 ILL_CLR  input  1  clears the sticky illegal flag.
REQ-010 Q  output  WIDTH  registered state.
REQ-011 Qbar  output  WIDTH  bitwise complement of Q at all times.
REQ-012 ILL  output  1  sticky flag: an SR-mode S=R=1 condition was accepted.
REQ-013 ILL_CNT  output  CNT_W  illegal-event count; present only when MS_FF_ILLCNT_EN is defined.

Function
REQ-014 Per bit, on a rising C edge with CLR=0 and EN=1, the next state is set by MODE.
- SR: 10->1; 01->0; 00->hold; 11->hold.
- JK: 10->1; 01->0; 00->hold; 11->toggle.
- D: Q<=A.
- T: A=1 toggles the bit; A=0 holds it.
REQ-015 MODE, A and B are sampled only at the rising edge; a MODE change takes effect on the first edge at which it is sampled; no intermediate state is kept across modes.
REQ-016 Latency: one cycle from the sampled inputs to Q; Q is stable between rising edges regardless of input changes, so there is no transparency.
REQ-017 Qbar is never equal to Q on any bit, including during and after reset and during an SR S=R=1 condition.
REQ-018 Illegal event: the sampled edge has CLR=0, EN=1, MODE=00, and at least one bit has A=B=1. Any number of offending bits in one cycle counts as one event.
REQ-019 ILL is set on the edge following an illegal event and stays 1 until cleared.
REQ-020 ILL_CLR=1 clears ILL on the next edge. If ILL_CLR and an illegal event occur on the same edge, set wins and ILL=1.
REQ-021 With EN=0, Q holds, illegal events are not detected, and ILL_CLR still acts.

Reset
REQ-022 CLR=1 at a rising edge gives Q=0, Qbar=all ones, ILL=0 and ILL_CNT=0, overriding EN, MODE, ILL_CLR and all data.
REQ-023 A CLR asserted mid-sequence, including during an SR S=R=1 condition, takes priority on that edge; normal operation resumes on the first edge with CLR=0.
REQ-024 No asynchronous behaviour: the outputs do not change on CLR alone without a C edge.

Configuration
REQ-025 Macro MS_FF_ILLCNT_EN. When defined, port ILL_CNT exists and counts illegal events.
- It increments by 1 per illegal event.
- It saturates at 2^CNT_W-1.
- It is cleared by CLR only; ILL_CLR does not affect it.
REQ-026 Without MS_FF_ILLCNT_EN, port ILL_CNT and its counter logic are absent; all other behaviour is identical.

Verification
REQ-027 WIDTH=8, CLR=1 for one edge, then CLR=0 -> Q=00, Qbar=FF, ILL=0 (ILL_CNT=0 if enabled).
REQ-028 MODE=00, EN=1 sequence:
- A=FF,B=00 -> Q=FF.
- A=00,B=0F -> Q=F0.
- A=00,B=00 -> Q=F0 (hold).
- A=01,B=01 -> Q=F0, ILL=1 on the next cycle.
REQ-029 MODE=01, Q=F0, A=FF,B=FF for three edges -> Q=0F, F0, 0F.
MODE=11, A=81 -> Q toggles bits 7 and 0 on each edge.
REQ-030 MODE=10, A=5A with EN=0 for two edges -> Q unchanged; then EN=1 for one edge -> Q=5A, Qbar=A5.
REQ-031 ILL=1, then ILL_CLR=1 together with an SR A=B=80 edge -> ILL stays 1; next edge with ILL_CLR=1 and no event -> ILL=0.
REQ-032 MS_FF_ILLCNT_EN defined, CNT_W=2, five illegal events -> ILL_CNT=1,2,3,3,3; ILL_CLR leaves ILL_CNT=3; CLR -> ILL_CNT=0.
